// File: rtl/divide_key_led.sv
// -----------------------------------------------------------------------------
// divide_key_led
// Front end for the charger/timer controller:
//   - clock divider producing div (50% duty) and an internal one-clk tick
//   - debounced 4x4 active-low matrix keypad scanner
//   - 4-digit multiplexed 7-segment display driver
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          asynchronous active-high reset
//   row[3:0]     keypad rows, active-low
//   circ[3:0]    column select, one-hot active-low
//   last_valid   last debounced key code (col*4 + row)
//   en           high while a debounced key is held
//   enable[3:0]  per-digit display enable
//   num0..num3   hex value shown on digit 0..3
//   dig[3:0]     digit select, active-low
//   abcdefg[6:0] segments, [6]=a ... [0]=g
//   div          divided clock, period 2*NTIMES clk
//
// Build option
//   SEG_ACTIVE_LOW_EN  when defined, abcdefg is driven inverted (common anode).
// -----------------------------------------------------------------------------
module divide_key_led #(
    parameter int unsigned NTIMES         = 99206,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] circ,
    output logic [3:0] last_valid,
    output logic       en,
    input  logic [3:0] enable,
    input  logic [3:0] num0,
    input  logic [3:0] num1,
    input  logic [3:0] num2,
    input  logic [3:0] num3,
    output logic [3:0] dig,
    output logic [6:0] abcdefg,
    output logic       div
);

    localparam int unsigned CNT_W = (NTIMES > 1) ? $clog2(NTIMES) : 1;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_TICKS);

    // ------------------------------------------------------------------
    // Divider and tick
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic             r_div;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(NTIMES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_div  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            if (w_wrap)
                r_div <= ~r_div;
            // Tick is high in exactly the cycle where div has just risen.
            r_tick <= w_wrap && !r_div;
        end
    end

    assign div = r_div;

    // ------------------------------------------------------------------
    // Keypad scanner
    // ------------------------------------------------------------------
    logic [1:0]      r_col;
    logic [3:0]      r_prev;
    logic            r_prev_vld;
    logic [DB_W-1:0] r_stab;
    logic [DB_W-1:0] r_rel;
    logic [3:0]      r_last;
    logic            r_en;

    logic            w_any;
    logic [1:0]      w_row_idx;
    logic [3:0]      w_cand;
    logic [DB_W-1:0] w_stab_nxt;
    logic [DB_W-1:0] w_rel_nxt;

    assign w_any = ~&row;

    // Lowest-index low row wins when several keys share the column.
    always_comb begin
        w_row_idx = 2'd3;
        casez (row)
            4'b???0: w_row_idx = 2'd0;
            4'b??01: w_row_idx = 2'd1;
            4'b?011: w_row_idx = 2'd2;
            default: w_row_idx = 2'd3;
        endcase
    end

    assign w_cand = {r_col, w_row_idx};

    always_comb begin
        w_stab_nxt = DB_W'(1);
        if (r_prev_vld && (r_prev == w_cand))
            w_stab_nxt = (r_stab >= DB_MAX) ? DB_MAX : r_stab + DB_W'(1);
        w_rel_nxt = (r_rel >= DB_MAX) ? DB_MAX : r_rel + DB_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col      <= 2'd0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_stab     <= '0;
            r_rel      <= '0;
            r_last     <= '0;
            r_en       <= 1'b0;
        end else if (r_tick) begin
            if (w_any) begin
                // Column is held while anything is pressed in it.
                r_prev     <= w_cand;
                r_prev_vld <= 1'b1;
                r_stab     <= w_stab_nxt;
                r_rel      <= '0;
                if (w_stab_nxt >= DB_MAX) begin
                    r_last <= w_cand;
                    r_en   <= 1'b1;
                end
            end else begin
                r_prev_vld <= 1'b0;
                r_stab     <= '0;
                r_rel      <= w_rel_nxt;
                if (w_rel_nxt >= DB_MAX)
                    r_en <= 1'b0;
                // Scan advances only once the previous key has been released,
                // judged by en as it stood entering this tick.
                if (!r_en)
                    r_col <= r_col + 2'd1;
            end
        end
    end

    assign circ       = ~(4'b0001 << r_col);
    assign last_valid = r_last;
    assign en         = r_en;

    // ------------------------------------------------------------------
    // Display multiplexer
    // ------------------------------------------------------------------
    function automatic logic [6:0] font(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    logic [1:0] r_ptr;
    logic [3:0] r_dig;
    logic [6:0] r_seg;
    logic [3:0] w_num;

    always_comb begin
        w_num = num0;
        case (r_ptr)
            2'd0: w_num = num0;
            2'd1: w_num = num1;
            2'd2: w_num = num2;
            default: w_num = num3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 2'd0;
            r_dig <= 4'hF;
            r_seg <= '0;
        end else if (r_tick) begin
            if (enable[r_ptr]) begin
                r_dig <= ~(4'b0001 << r_ptr);
                r_seg <= font(w_num);
            end else begin
                r_dig <= 4'hF;
                r_seg <= '0;
            end
            r_ptr <= r_ptr + 2'd1;
        end
    end

    assign dig = r_dig;

`ifdef SEG_ACTIVE_LOW_EN
    assign abcdefg = ~r_seg;
`else
    assign abcdefg = r_seg;
`endif

endmodule

// File: tb/tb_divide_key_led.sv
module tb_divide_key_led;

    localparam int NT = 4;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] circ;
    logic [3:0] last_valid;
    logic       en;
    logic [3:0] enable = '0;
    logic [3:0] num0 = '0;
    logic [3:0] num1 = '0;
    logic [3:0] num2 = '0;
    logic [3:0] num3 = '0;
    logic [3:0] dig;
    logic [6:0] abcdefg;
    logic       div;

    logic [15:0] keys = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int         m_n, m_col, m_prev, m_stab, m_rel, m_lv, m_p;
    bit         m_en;
    logic [3:0] m_dig;
    logic [6:0] m_seg;

    logic [6:0] font_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    divide_key_led #(.NTIMES(NT), .DEBOUNCE_TICKS(DB)) dut (
        .clk(clk), .rst(rst), .row(row), .circ(circ), .last_valid(last_valid),
        .en(en), .enable(enable), .num0(num0), .num1(num1), .num2(num2), .num3(num3),
        .dig(dig), .abcdefg(abcdefg), .div(div)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!circ[c])
                for (int r = 0; r < 4; r++)
                    if (keys[c*4 + r]) row[r] = 1'b0;
    end

    function automatic logic [6:0] seg_out(input logic [6:0] s);
`ifdef SEG_ACTIVE_LOW_EN
        return ~s;
`else
        return s;
`endif
    endfunction

    function automatic logic [3:0] col_sel(input int c);
        logic [3:0] v;
        v = 4'hF;
        v[c] = 1'b0;
        return v;
    endfunction

    function automatic logic exp_div();
        return ((m_n / NT) % 2) == 1;
    endfunction

    function automatic bit tick_edge();
        return (m_n % (2*NT)) == NT + 1;
    endfunction

    task automatic model_reset();
        m_n = 0; m_col = 0; m_prev = -1; m_stab = 0; m_rel = 0; m_lv = 0;
        m_p = 0; m_en = 0; m_dig = 4'hF; m_seg = '0;
    endtask

    task automatic model_tick();
        int hit;
        int cand;
        bit old_en;
        logic [3:0] nv;
        hit = -1;
        old_en = m_en;
        for (int r = 3; r >= 0; r--)
            if (keys[m_col*4 + r]) hit = r;
        if (hit >= 0) begin
            cand   = m_col*4 + hit;
            m_stab = (cand == m_prev) ? ((m_stab + 1 > DB) ? DB : m_stab + 1) : 1;
            m_prev = cand;
            m_rel  = 0;
            if (m_stab >= DB) begin
                m_lv = cand;
                m_en = 1;
            end
        end else begin
            m_rel  = (m_rel + 1 > DB) ? DB : m_rel + 1;
            if (m_rel >= DB) m_en = 0;
            if (!old_en) m_col = (m_col + 1) % 4;
            m_prev = -1;
            m_stab = 0;
        end
        case (m_p)
            0: nv = num0;
            1: nv = num1;
            2: nv = num2;
            default: nv = num3;
        endcase
        if (enable[m_p]) begin
            m_dig = col_sel(m_p);
            m_seg = font_tab[nv];
        end else begin
            m_dig = 4'hF;
            m_seg = '0;
        end
        m_p = (m_p + 1) % 4;
    endtask

    // Advance one clock; inputs are stable across the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        m_n++;
        if (tick_edge()) model_tick();
        #1;
    endtask

    task automatic wait_col(input int c);
        int guard;
        guard = 0;
        while (!(m_col == c && tick_edge()) && guard < 200) begin
            step();
            guard++;
        end
        n_cmp++;
        if (guard >= 200) begin
            n_bad++;
            $display("FAIL wait_col: column %0d not reached, got col %0d", c, m_col);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        n_cmp += 6;
        if (div !== 1'b0)        begin n_bad++; $display("FAIL reset_div got %b exp 0", div); end
        if (circ !== 4'b1110)    begin n_bad++; $display("FAIL reset_circ got %b exp 1110", circ); end
        if (last_valid !== 4'd0) begin n_bad++; $display("FAIL reset_lv got %0d exp 0", last_valid); end
        if (en !== 1'b0)         begin n_bad++; $display("FAIL reset_en got %b exp 0", en); end
        if (dig !== 4'hF)        begin n_bad++; $display("FAIL reset_dig got %b exp 1111", dig); end
        if (abcdefg !== seg_out(7'h00)) begin
            n_bad++; $display("FAIL reset_seg got %h exp %h", abcdefg, seg_out(7'h00));
        end
    endtask

    task automatic test_divider();
        repeat (40) begin
            step();
            n_cmp++;
            if (div !== exp_div()) begin
                n_bad++; $display("FAIL div cyc %0d got %b exp %b", m_n, div, exp_div());
            end
        end
    endtask

    task automatic test_key_press();
        keys = '0;
        wait_col(2);
        keys[9] = 1'b1;
        repeat (48) begin
            step();
            n_cmp += 3;
            if (en !== m_en)                 begin n_bad++; $display("FAIL press_en got %b exp %b", en, m_en); end
            if (last_valid !== 4'(m_lv))     begin n_bad++; $display("FAIL press_lv got %0d exp %0d", last_valid, m_lv); end
            if (circ !== col_sel(m_col))     begin n_bad++; $display("FAIL press_circ got %b exp %b", circ, col_sel(m_col)); end
        end
        n_cmp += 3;
        if (last_valid !== 4'd9) begin n_bad++; $display("FAIL held_lv got %0d exp 9", last_valid); end
        if (en !== 1'b1)         begin n_bad++; $display("FAIL held_en got %b exp 1", en); end
        if (circ !== 4'b1011)    begin n_bad++; $display("FAIL held_circ got %b exp 1011", circ); end
        keys = '0;
        repeat (48) begin
            step();
            n_cmp += 2;
            if (en !== m_en)             begin n_bad++; $display("FAIL release_en got %b exp %b", en, m_en); end
            if (circ !== col_sel(m_col)) begin n_bad++; $display("FAIL release_circ got %b exp %b", circ, col_sel(m_col)); end
        end
        n_cmp += 2;
        if (en !== 1'b0)         begin n_bad++; $display("FAIL released_en got %b exp 0", en); end
        if (last_valid !== 4'd9) begin n_bad++; $display("FAIL released_lv got %0d exp 9", last_valid); end
    endtask

    task automatic test_bounce();
        wait_col(1);
        keys[6] = 1'b1;
        repeat (16) step();
        keys = '0;
        repeat (64) begin
            step();
            n_cmp++;
            if (en !== 1'b0) begin n_bad++; $display("FAIL bounce_en got %b exp 0", en); end
        end
        n_cmp++;
        if (last_valid !== 4'd9) begin n_bad++; $display("FAIL bounce_lv got %0d exp 9", last_valid); end
    endtask

    task automatic test_display();
        enable = 4'b0101;
        num0 = 4'hA;
        num1 = 4'($urandom);
        num2 = 4'h3;
        num3 = 4'($urandom);
        repeat (48) begin
            step();
            n_cmp += 2;
            if (dig !== m_dig)              begin n_bad++; $display("FAIL disp_dig got %b exp %b", dig, m_dig); end
            if (abcdefg !== seg_out(m_seg)) begin n_bad++; $display("FAIL disp_seg got %h exp %h", abcdefg, seg_out(m_seg)); end
            if (dig == 4'b1110) begin
                n_cmp++;
                if (abcdefg !== seg_out(7'h77)) begin n_bad++; $display("FAIL disp_digit0 got %h exp %h", abcdefg, seg_out(7'h77)); end
            end
            if (dig == 4'b1011) begin
                n_cmp++;
                if (abcdefg !== seg_out(7'h79)) begin n_bad++; $display("FAIL disp_digit2 got %h exp %h", abcdefg, seg_out(7'h79)); end
            end
            if (dig == 4'b1111) begin
                n_cmp++;
                if (abcdefg !== seg_out(7'h00)) begin n_bad++; $display("FAIL disp_blank got %h exp %h", abcdefg, seg_out(7'h00)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_col(3);
        keys[13] = 1'b1;
        repeat (20) step();
        rst = 1'b1;
        #1;
        n_cmp += 6;
        if (div !== 1'b0)        begin n_bad++; $display("FAIL midrst_div got %b exp 0", div); end
        if (circ !== 4'b1110)    begin n_bad++; $display("FAIL midrst_circ got %b exp 1110", circ); end
        if (last_valid !== 4'd0) begin n_bad++; $display("FAIL midrst_lv got %0d exp 0", last_valid); end
        if (en !== 1'b0)         begin n_bad++; $display("FAIL midrst_en got %b exp 0", en); end
        if (dig !== 4'hF)        begin n_bad++; $display("FAIL midrst_dig got %b exp 1111", dig); end
        if (abcdefg !== seg_out(7'h00)) begin n_bad++; $display("FAIL midrst_seg got %h exp %h", abcdefg, seg_out(7'h00)); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (120) begin
            step();
            n_cmp += 3;
            if (en !== m_en)             begin n_bad++; $display("FAIL requal_en got %b exp %b", en, m_en); end
            if (last_valid !== 4'(m_lv)) begin n_bad++; $display("FAIL requal_lv got %0d exp %0d", last_valid, m_lv); end
            if (circ !== col_sel(m_col)) begin n_bad++; $display("FAIL requal_circ got %b exp %b", circ, col_sel(m_col)); end
        end
        n_cmp += 2;
        if (last_valid !== 4'd13) begin n_bad++; $display("FAIL requal_final_lv got %0d exp 13", last_valid); end
        if (en !== 1'b1)          begin n_bad++; $display("FAIL requal_final_en got %b exp 1", en); end
        keys = '0;
    endtask

    task automatic test_random();
        int r;
        repeat (3000) begin
            r = int'($urandom_range(0, 99));
            if (r < 3)      keys = '0;
            else if (r < 5) keys = 16'(1) << $urandom_range(0, 15);
            else if (r < 6) keys = keys | (16'(1) << $urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) begin
                enable = 4'($urandom);
                num0 = 4'($urandom); num1 = 4'($urandom);
                num2 = 4'($urandom); num3 = 4'($urandom);
            end
            step();
            n_cmp += 6;
            if (div !== exp_div())          begin n_bad++; $display("FAIL rnd_div cyc %0d got %b exp %b", m_n, div, exp_div()); end
            if (circ !== col_sel(m_col))    begin n_bad++; $display("FAIL rnd_circ cyc %0d got %b exp %b", m_n, circ, col_sel(m_col)); end
            if (en !== m_en)                begin n_bad++; $display("FAIL rnd_en cyc %0d got %b exp %b", m_n, en, m_en); end
            if (last_valid !== 4'(m_lv))    begin n_bad++; $display("FAIL rnd_lv cyc %0d got %0d exp %0d", m_n, last_valid, m_lv); end
            if (dig !== m_dig)              begin n_bad++; $display("FAIL rnd_dig cyc %0d got %b exp %b", m_n, dig, m_dig); end
            if (abcdefg !== seg_out(m_seg)) begin n_bad++; $display("FAIL rnd_seg cyc %0d got %h exp %h", m_n, abcdefg, seg_out(m_seg)); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_divider();
        test_key_press();
        test_bounce();
        test_display();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
